// File: rtl/jtframe_ioctl_sdram.sv
// jtframe_ioctl_sdram: packs download bytes into 16-bit words with byte enables
// and queues them in a small FIFO for the SDRAM programming port.
module jtframe_ioctl_sdram #(
  parameter int AW         = 22,
  parameter int DEPTH_LOG2 = 3,
  parameter int SWAB       = 0
)(
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [26:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_ben,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          dwnld_busy,
  output logic          ovf
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    ben;
  } entry_t;
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  entry_t                pw_q, pw_d, push_e, head;
  logic [DEPTH_LOG2:0]   wp_q, wp_d, rp_q, rp_d;
  logic                  pw_valid_q, pw_valid_d, dl_q, ovf_q, ovf_d, busy_q, busy_d;
  logic                  acc, lane, empty, full, pop, push, wr_ok, same;
  logic [AW-1:0]         waddr;
  logic [1:0]            bmask;
  logic                  unused_addr;
  assign unused_addr = ^ioctl_addr[26:AW+1];
  assign acc   = ioctl_wr & ioctl_download;
  assign lane  = ioctl_addr[0] ^ (SWAB == 0);
  assign waddr = ioctl_addr[AW:1];
  assign bmask = lane ? 2'b10 : 2'b01;
  assign same  = pw_valid_q && waddr == pw_q.addr;
  assign empty = wp_q == rp_q;
  assign full  = wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2] &&
                 wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0];
  assign pop   = !empty & prog_rdy;
  assign head  = mem_q[rp_q[DEPTH_LOG2-1:0]];
  always_comb begin
    pw_d       = pw_q;
    pw_valid_d = pw_valid_q;
    push       = 1'b0;
    push_e     = pw_q;
    if (acc && same) begin
      pw_d.ben  = pw_q.ben | bmask;
      pw_d.data = lane ? {ioctl_dout, pw_q.data[7:0]} : {pw_q.data[15:8], ioctl_dout};
      push       = pw_d.ben == 2'b11;
      push_e     = pw_d;
      pw_valid_d = pw_d.ben != 2'b11;
    end else if (acc) begin
      push       = pw_valid_q;
      pw_d       = '{addr: waddr, data: {ioctl_dout, ioctl_dout}, ben: bmask};
      pw_valid_d = 1'b1;
    end else if (dl_q && !ioctl_download && pw_valid_q) begin
      push       = 1'b1;
      pw_valid_d = 1'b0;
    end
  end
  // A push into a full FIFO still fits when the head leaves on the same edge.
  always_comb begin
    wr_ok = push & (!full | pop);
    mem_d = mem_q;
    if (wr_ok) mem_d[wp_q[DEPTH_LOG2-1:0]] = push_e;
    wp_d   = wr_ok ? wp_q + PTR_ONE : wp_q;
    rp_d   = pop ? rp_q + PTR_ONE : rp_q;
    ovf_d  = (push && !wr_ok) || (ovf_q && !(!dl_q && ioctl_download));
    busy_d = ioctl_download | pw_valid_q | !empty;
  end
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      pw_q       <= '0;
      pw_valid_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      dl_q       <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      pw_q       <= pw_d;
      pw_valid_q <= pw_valid_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      dl_q       <= ioctl_download;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end
  assign prog_we    = !empty;
  assign prog_addr  = head.addr;
  assign prog_data  = head.data;
  assign prog_ben   = head.ben;
  assign dwnld_busy = busy_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_jtframe_ioctl_sdram.sv
// tb_jtframe_ioctl_sdram: randomized and directed download traffic; a byte-level
// reference model fills a scoreboard queue that a negedge monitor drains.
module tb_jtframe_ioctl_sdram;
  logic        clk_sys = 0, rst_n = 0, ioctl_download = 0, ioctl_wr = 0, prog_rdy = 0;
  logic [26:0] ioctl_addr = 0;
  logic [7:0]  ioctl_dout = 0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data, m;
  logic [1:0]  prog_ben;
  logic        prog_we, dwnld_busy, ovf;
  int          total = 0, bad = 0;
  typedef struct packed {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  b;
  } ent_t;
  ent_t        q[$];
  ent_t        pw;
  logic [21:0] wa;
  logic [1:0]  lb;
  bit          pv, dl_m, ovf_m, busy_m, popped, ne;
  always #5 clk_sys = ~clk_sys;
  jtframe_ioctl_sdram dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_ben(prog_ben), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .ovf(ovf)
  );
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask
  function automatic void mpush(ent_t e);
    if (q.size() < 8) q.push_back(e);
    else ovf_m = 1;
  endfunction
  // Reference model: byte packing rules applied at each clock edge.
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pv = 0; dl_m = 0; ovf_m = 0; busy_m = 0; popped = 0;
    end else begin
      ne = q.size() != 0 || popped;
      popped = 0;
      busy_m = ioctl_download | pv | ne;
      if (!dl_m && ioctl_download) ovf_m = 0;
      if (ioctl_wr && ioctl_download) begin
        wa = ioctl_addr[22:1];
        lb = ioctl_addr[0] ? 2'b01 : 2'b10;
        if (pv && wa == pw.a) begin
          pw.b = pw.b | lb;
          if (lb[1]) pw.d[15:8] = ioctl_dout;
          else pw.d[7:0] = ioctl_dout;
          if (pw.b == 2'b11) begin mpush(pw); pv = 0; end
        end else begin
          if (pv) mpush(pw);
          pw.a = wa; pw.b = lb;
          pw.d = lb[1] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
          pv = 1;
        end
      end else if (dl_m && !ioctl_download && pv) begin
        mpush(pw);
        pv = 0;
      end
      dl_m = ioctl_download;
    end
  end
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      chk("rst_we", prog_we, 0);
      chk("rst_busy", dwnld_busy, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_head", {prog_addr, prog_data, prog_ben}, 0);
    end else begin
      chk("we", prog_we, q.size() != 0);
      chk("ovf", ovf, ovf_m);
      chk("busy", dwnld_busy, busy_m);
      if (q.size() != 0) begin
        m = {{8{q[0].b[1]}}, {8{q[0].b[0]}}};
        chk("addr", prog_addr, q[0].a);
        chk("ben", prog_ben, q[0].b);
        chk("data", prog_data & m, q[0].d & m);
        if (prog_rdy) begin
          void'(q.pop_front());
          popped = 1;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic wr(input logic [26:0] a, input logic [7:0] d);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 0;
  endtask
  task automatic dl(input logic v);
    ioctl_download = v;
    step();
  endtask
  task automatic drain();
    int n = 0;
    ioctl_download = 0;
    prog_rdy = 1;
    step();
    while ((dwnld_busy || q.size() != 0) && n < 300) begin step(); n++; end
    chk("drain_bound", n < 300, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    int ptr;
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1;
    step();
    // word pack
    dl(1);
    wr(0, 8'h11); wr(1, 8'h22);
    chk("t1_we", prog_we, 1);
    chk("t1_word", {prog_addr, prog_data, prog_ben}, {22'd0, 16'h1122, 2'b11});
    drain();
    // partial flush at end of download
    dl(1);
    wr(4, 8'h44); wr(5, 8'h55); wr(6, 8'h66);
    dl(0);
    drain();
    // address gap flushes the partial word
    prog_rdy = 0;
    dl(1);
    wr(10, 8'hA0); step(); wr(20, 8'hB0);
    chk("t3_word", {prog_addr, prog_ben}, {22'd5, 2'b10});
    dl(0);
    drain();
    // overflow with a stalled controller
    prog_rdy = 0;
    dl(1);
    for (int i = 0; i < 18; i++) wr(27'(100 + i), 8'($urandom));
    chk("t4_ovf", ovf, 1);
    drain();
    dl(1);
    chk("t4_ovf_clr", ovf, 0);
    dl(0);
    // continuous stream, always ready
    prog_rdy = 1;
    dl(1);
    for (int i = 0; i < 40; i++) wr(27'(200 + i), 8'($urandom));
    dl(0);
    drain();
    // reset mid-stream
    prog_rdy = 0;
    dl(1);
    for (int i = 0; i < 10; i++) wr(27'(300 + i), 8'($urandom));
    rst_n = 0;
    #1;
    chk("t6_we", prog_we, 0);
    chk("t6_busy", dwnld_busy, 0);
    ioctl_download = 0;
    step(); step();
    rst_n = 1;
    step();
    dl(1);
    wr(400, 8'h12); wr(401, 8'h34);
    drain();
    // random traffic
    ptr = 1000;
    for (int i = 0; i < 800; i++) begin
      prog_rdy = ($urandom % 3) != 0;
      case ($urandom % 10)
        0, 1, 2, 3, 4, 5: begin
          if ($urandom % 8 == 0) ptr = $urandom % 5000;
          wr({4'($urandom), 23'(ptr)}, 8'($urandom));
          ptr = ptr + (($urandom % 6 == 0) ? 0 : 1);
        end
        6: dl(!ioctl_download);
        7: wr(27'($urandom), 8'($urandom));
        default: step();
      endcase
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
